// File: rtl/ava_alu_pkg.sv
// Shared constants for the ava_alu_seq Avalon-MM ALU slave: op codes, register map,
// STATUS bit positions and the control FSM state type.
package ava_alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;

  localparam logic [2:0] REG_A         = 3'd0;
  localparam logic [2:0] REG_B         = 3'd1;
  localparam logic [2:0] REG_OP        = 3'd2;
  localparam logic [2:0] REG_RESULT    = 3'd3;
  localparam logic [2:0] REG_RESULT_HI = 3'd4;
  localparam logic [2:0] REG_STATUS    = 3'd5;

  localparam int unsigned ST_BUSY_BIT = 0;
  localparam int unsigned ST_DONE_BIT = 1;
  localparam int unsigned ST_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_e;

  // An op code starts work only if legal; NOP is handled separately by the caller.
  function automatic logic op_legal(input logic [3:0] op, input logic mul_en);
    logic ok;
    ok = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
         (op == OP_XOR) || (op == OP_SHL) || (op == OP_SHR);
    return ok || ((op == OP_MUL) && mul_en);
  endfunction

endpackage

// File: rtl/ava_alu_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle for DW cycles.
// The first bit is consumed on the start edge so done is a registered pulse in the last cycle.
module ava_alu_mul #(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            done,
  output logic [2*DW-1:0] product
);

  localparam int unsigned CW = $clog2(DW);

  logic [DW-1:0]  mcand_q;
  logic [2*DW:0]  acc_q;
  logic [CW-1:0]  cnt_q;
  logic           active_q;
  logic           done_q;

  // Upper half accumulates the multiplicand, lower half holds the remaining multiplier bits.
  function automatic logic [2*DW:0] step(input logic [2*DW:0] p, input logic [DW-1:0] m);
    logic [DW:0] sum;
    sum = p[2*DW:DW] + (p[0] ? {1'b0, m} : {(DW+1){1'b0}});
    return {1'b0, sum, p[DW-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      acc_q    <= step({{(DW+1){1'b0}}, b}, a);
      cnt_q    <= CW'(1);
      active_q <= 1'b1;
      done_q   <= 1'b0;
    end else if (active_q) begin
      acc_q <= step(acc_q, mcand_q);
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(DW - 1)) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done    = done_q;
  assign product = acc_q[2*DW-1:0];

endmodule

// File: rtl/ava_alu_seq.sv
// Avalon-MM ALU slave with status register and stalling waitrequest.
// Define AVA_ALU_MUL_EN to build the iterative multiplier (op 6) and RESULT_HI.
module ava_alu_seq
  import ava_alu_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ava_chipselect,
  input  logic [2:0]      ava_address,
  input  logic            ava_read,
  input  logic            ava_write,
  input  logic [DW/8-1:0] ava_byteenable,
  input  logic [DW-1:0]   ava_writedata,
  output logic [DW-1:0]   ava_readdata,
  output logic            ava_waitrequest
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned SW = $clog2(DW);
`ifdef AVA_ALU_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif

  state_e        state_q;
  logic [DW-1:0] a_q, b_q, op_q, result_q;
  logic          done_q, err_q;
  logic          busy;
  logic          rd_stall, wr_stall, wr_acc;
  logic [DW-1:0] wr_old, wr_merged;
  logic [3:0]    new_code;
  logic          op_start;
  logic [DW-1:0] alu;
  logic [DW-1:0] status;

`ifdef AVA_ALU_MUL_EN
  logic [DW-1:0]   result_hi_q;
  logic            mul_start, mul_done;
  logic [2*DW-1:0] mul_product;

  assign mul_start = op_start && (new_code == OP_MUL);

  ava_alu_mul #(.DW(DW)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_q),
    .b       (b_q),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  assign busy = (state_q != IDLE);

  // Stall only accesses that would observe or disturb an in-flight operation.
  always_comb begin
    rd_stall = ava_read && ((ava_address == REG_RESULT) || (ava_address == REG_RESULT_HI));
    wr_stall = ava_write && ((ava_address == REG_A) || (ava_address == REG_B) ||
                             (ava_address == REG_OP));
    ava_waitrequest = ava_chipselect && busy && (rd_stall || wr_stall);
    wr_acc = ava_chipselect && ava_write && !ava_waitrequest;
  end

  always_comb begin
    case (ava_address)
      REG_A:   wr_old = a_q;
      REG_B:   wr_old = b_q;
      REG_OP:  wr_old = op_q;
      default: wr_old = '0;
    endcase
    wr_merged = wr_old;
    for (int i = 0; i < NB; i++) begin
      if (ava_byteenable[i]) wr_merged[8*i +: 8] = ava_writedata[8*i +: 8];
    end
    new_code = wr_merged[3:0];
    op_start = wr_acc && (ava_address == REG_OP) && op_legal(new_code, MUL_EN);
  end

  always_comb begin
    case (op_q[3:0])
      OP_ADD:  alu = a_q + b_q;
      OP_SUB:  alu = a_q - b_q;
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      OP_XOR:  alu = a_q ^ b_q;
      OP_SHL:  alu = a_q << b_q[SW-1:0];
      OP_SHR:  alu = a_q >> b_q[SW-1:0];
      default: alu = result_q;
    endcase
  end

  always_comb begin
    status = '0;
    status[ST_BUSY_BIT] = busy;
    status[ST_DONE_BIT] = done_q;
    status[ST_ERR_BIT]  = err_q;
    case (ava_address)
      REG_A:         ava_readdata = a_q;
      REG_B:         ava_readdata = b_q;
      REG_OP:        ava_readdata = op_q;
      REG_RESULT:    ava_readdata = result_q;
`ifdef AVA_ALU_MUL_EN
      REG_RESULT_HI: ava_readdata = result_hi_q;
`endif
      REG_STATUS:    ava_readdata = status;
      default:       ava_readdata = '0;
    endcase
  end

  // Register file and control FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef AVA_ALU_MUL_EN
      result_hi_q <= '0;
`endif
    end else begin
      if (wr_acc) begin
        case (ava_address)
          REG_A:  a_q <= wr_merged;
          REG_B:  b_q <= wr_merged;
          REG_OP: begin
            op_q   <= wr_merged;
            done_q <= 1'b0;
            err_q  <= (new_code != OP_NOP) && !op_legal(new_code, MUL_EN);
            if (op_start) state_q <= (new_code == OP_MUL) ? MUL : EXEC;
          end
          default: ;
        endcase
      end
      case (state_q)
        EXEC: begin
          result_q <= alu;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
`ifdef AVA_ALU_MUL_EN
        MUL: begin
          if (mul_done) begin
            result_q    <= mul_product[DW-1:0];
            result_hi_q <= mul_product[2*DW-1:DW];
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ava_alu_seq.sv
// Self-checking bench for ava_alu_seq: directed register-map scenarios plus random traffic
// checked every cycle against a transaction-level model of the ALU slave.
`timescale 1ns/1ps
module tb_ava_alu_seq;

  localparam int unsigned DW = 32;
`ifdef AVA_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [2:0]  addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wd = '0;
  logic [31:0] rdata;
  logic        wait_s;

  always #5 clk = ~clk;

  ava_alu_seq #(.DW(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .ava_chipselect  (cs),
    .ava_address     (addr),
    .ava_read        (rd),
    .ava_write       (wr),
    .ava_byteenable  (be),
    .ava_writedata   (wd),
    .ava_readdata    (rdata),
    .ava_waitrequest (wait_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: registers plus a countdown of remaining busy cycles.
  logic [31:0] m_a = '0, m_b = '0, m_op = '0, m_res = '0, m_hi = '0;
  bit          m_done = 0, m_err = 0, m_valid = 0, m_pend_mul = 0;
  int          m_busy = 0;
  logic [63:0] m_pend = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] en);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic bit exp_wait();
    bit hazard;
    hazard = (rd && (addr == 3'd3 || addr == 3'd4)) || (wr && addr <= 3'd2);
    return cs && (m_busy > 0) && hazard;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    case (a)
      3'd0: return m_a;
      3'd1: return m_b;
      3'd2: return m_op;
      3'd3: return m_res;
      3'd4: return MUL_EN ? m_hi : 32'h0;
      3'd5: return {29'h0, m_err, m_done, m_busy > 0};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit          acc;
    logic [3:0]  code;
    acc = cs && wr && !exp_wait();
    if (!reset) begin
      m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_hi = '0;
      m_done = 0; m_err = 0; m_busy = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_res = m_pend[31:0];
          if (m_pend_mul) m_hi = m_pend[63:32];
          m_done = 1;
        end
      end
      if (acc) begin
        case (addr)
          3'd0: m_a = merge(m_a, wd, be);
          3'd1: m_b = merge(m_b, wd, be);
          3'd2: begin
            m_op = merge(m_op, wd, be);
            code = m_op[3:0];
            m_done = 0;
            m_err = 0;
            m_pend_mul = 0;
            case (code)
              4'd0: ;
              4'd1: begin m_pend = {32'h0, m_a + m_b};          m_busy = 1; end
              4'd2: begin m_pend = {32'h0, m_a - m_b};          m_busy = 1; end
              4'd3: begin m_pend = {32'h0, m_a & m_b};          m_busy = 1; end
              4'd4: begin m_pend = {32'h0, m_a | m_b};          m_busy = 1; end
              4'd5: begin m_pend = {32'h0, m_a ^ m_b};          m_busy = 1; end
              4'd7: begin m_pend = {32'h0, m_a << m_b[4:0]};    m_busy = 1; end
              4'd8: begin m_pend = {32'h0, m_a >> m_b[4:0]};    m_busy = 1; end
              4'd6: begin
                if (MUL_EN) begin
                  m_pend = 64'(m_a) * 64'(m_b);
                  m_pend_mul = 1;
                  m_busy = DW;
                end else begin
                  m_err = 1;
                end
              end
              default: m_err = 1;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid && reset) begin
      check("waitrequest", 64'(wait_s), 64'(exp_wait()));
      if (cs && rd && !wr && !exp_wait())
        check($sformatf("readdata[%0d]", addr), 64'(rdata), 64'(exp_read(addr)));
    end
  end

  // One Avalon access; the request is held while waitrequest is high.
  task automatic access(input bit is_wr, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] en, output logic [31:0] q, output int stalls);
    bit fin;
    cs = 1; rd = !is_wr; wr = is_wr; addr = a; wd = d; be = en;
    stalls = 0; fin = 0; q = '0;
    while (!fin) begin
      @(negedge clk);
      if (!wait_s) begin
        q = rdata;
        fin = 1;
      end else begin
        stalls++;
        if (stalls > 200) begin
          check("stall_timeout", 64'(stalls), 64'(0));
          fin = 1;
        end
      end
      @(posedge clk); #1;
    end
    cs = 0; rd = 0; wr = 0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] en = 4'hF);
    logic [31:0] q;
    int s;
    access(1'b1, a, d, en, q, s);
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] q, output int s);
    access(1'b0, a, 32'h0, 4'h0, q, s);
  endtask

  initial begin
    logic [31:0] q, prev;
    int          s;

    reset = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    check("reset_wait", 64'(wait_s), 64'(0));
    @(posedge clk); #1;
    rd_reg(3'd0, q, s);  check("reset_a", 64'(q), 64'h0);
    rd_reg(3'd5, q, s);  check("reset_status", 64'(q), 64'h0);

    wr_reg(3'd0, 32'h0123_4567);
    wr_reg(3'd1, 32'h0123_4568);
    wr_reg(3'd2, 32'd1);
    rd_reg(3'd3, q, s);  check("add_result", 64'(q), 64'h0246_8ACF);
    rd_reg(3'd5, q, s);  check("add_status", 64'(q), 64'h2);
    wr_reg(3'd2, 32'd2);
    rd_reg(3'd3, q, s);  check("sub_result", 64'(q), 64'hFFFF_FFFF);
    wr_reg(3'd2, 32'd5);
    rd_reg(3'd3, q, s);  check("xor_result", 64'(q), 64'h0000_000F);

    wr_reg(3'd0, 32'h0001_0000);
    wr_reg(3'd1, 32'h0001_0000);
    wr_reg(3'd2, 32'd6);
    rd_reg(3'd3, q, s);
`ifdef AVA_ALU_MUL_EN
    check("mul_stall_cycles", 64'(s), 64'd32);
    check("mul_result", 64'(q), 64'h0);
    rd_reg(3'd4, q, s);  check("mul_result_hi", 64'(q), 64'h1);
    wr_reg(3'd2, 32'd6);
    rd_reg(3'd5, q, s);  check("mul_status_busy", 64'(q), 64'h1);
    check("status_no_stall", 64'(s), 64'd0);
    rd_reg(3'd3, q, s);
    prev = 32'h0;
`else
    check("mul_illegal_no_stall", 64'(s), 64'd0);
    check("mul_illegal_result", 64'(q), 64'h0000_000F);
    rd_reg(3'd5, q, s);  check("mul_illegal_status", 64'(q), 64'h4);
    prev = 32'h0000_000F;
`endif

    wr_reg(3'd2, 32'd9);
    rd_reg(3'd5, q, s);  check("illegal_status", 64'(q), 64'h4);
    rd_reg(3'd3, q, s);  check("illegal_result", 64'(q), 64'(prev));
    check("illegal_no_stall", 64'(s), 64'd0);

    wr_reg(3'd0, 32'hFFFF_FFFF);
    wr_reg(3'd0, 32'h0000_1234, 4'b0011);
    rd_reg(3'd0, q, s);  check("byteenable_a", 64'(q), 64'hFFFF_1234);

    wr_reg(3'd0, 32'd3);
    wr_reg(3'd1, 32'd5);
    wr_reg(3'd2, 32'd1);
    rd_reg(3'd3, q, s);  check("pre_reset_add", 64'(q), 64'h8);
    wr_reg(3'd2, 32'd6);
    repeat (9) @(posedge clk);
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    check("post_reset_wait", 64'(wait_s), 64'(0));
    @(posedge clk); #1;
    rd_reg(3'd5, q, s);  check("post_reset_status", 64'(q), 64'h0);
    rd_reg(3'd3, q, s);  check("post_reset_result", 64'(q), 64'h0);

    // Random traffic; every cycle is checked by the compare process.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  ra;
      logic [31:0] rdat;
      logic [3:0]  ren;
      bit          is_wr;
      ra    = 3'($urandom_range(0, 7));
      is_wr = ($urandom_range(0, 1) == 1);
      rdat  = $urandom();
      ren   = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom());
      if (is_wr && $urandom_range(0, 2) == 0) ra = 3'd2;
      if (ra == 3'd2) rdat[3:0] = ($urandom_range(0, 3) == 0) ? 4'($urandom()) :
                                   4'($urandom_range(1, 8));
      if ($urandom_range(0, 150) == 0) begin
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
      end
      access(is_wr, ra, rdat, ren, q, s);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end

    repeat (40) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
